// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - EX operand forwarding with WB hold buffer and load-use stall control
module fwd_hazard_unit #(
    parameter int XLEN       = 32,
    parameter int RW         = 5,
    parameter int NSRC       = 2,
    parameter int LOAD_STALL = 1,
    parameter int HOLD_EN    = 1,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [NSRC*RW-1:0]   id_rs,
    input  logic [NSRC*RW-1:0]   ex_rs,
    input  logic [NSRC*XLEN-1:0] ex_rdata,
    input  logic [RW-1:0]        ex_rd,
    input  logic                 ex_regwrite,
    input  logic                 ex_memread,
    input  logic [RW-1:0]        mem_rd,
    input  logic                 mem_regwrite,
    input  logic [XLEN-1:0]      mem_result,
    input  logic [RW-1:0]        wb_rd,
    input  logic                 wb_regwrite,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 cnt_clr,
    output logic [NSRC*XLEN-1:0] fwd_out,
    output logic [NSRC*2-1:0]    fwd_sel,
    output logic                 stall,
    output logic                 bubble,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     fwd_cnt
);

    if (NSRC < 1 || NSRC > 4) begin : g_bad_nsrc
        $error("fwd_hazard_unit: NSRC must be 1..4");
    end
    if (LOAD_STALL < 1 || LOAD_STALL > 3) begin : g_bad_load_stall
        $error("fwd_hazard_unit: LOAD_STALL must be 1..3");
    end
    if (HOLD_EN < 0 || HOLD_EN > 1) begin : g_bad_hold_en
        $error("fwd_hazard_unit: HOLD_EN must be 0 or 1");
    end
    if (XLEN < 1 || RW < 1 || CNT_W < 1) begin : g_bad_width
        $error("fwd_hazard_unit: XLEN, RW and CNT_W must be positive");
    end

    localparam logic       S_IDLE      = 1'b0;
    localparam logic       S_STALL     = 1'b1;
    localparam int         SCNT_INIT_I = (LOAD_STALL > 1) ? LOAD_STALL - 2 : 0;
    localparam logic [1:0] SCNT_INIT   = 2'(SCNT_INIT_I);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              hold_v_q, hold_v_d;
    logic [RW-1:0]     hold_rd_q, hold_rd_d;
    logic [XLEN-1:0]   hold_data_q, hold_data_d;
    logic              state_q, state_d;
    logic [1:0]        scnt_q, scnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  fwd_cnt_q, fwd_cnt_d;
    logic [NSRC-1:0]   fwd_any;
    logic [NSRC-1:0]   rs_hit;
    logic              load_use;
    logic              stall_int;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        logic [RW-1:0]   src;
        logic            mem_hit, wb_hit, hold_hit;
        logic [1:0]      sel;
        logic [XLEN-1:0] data;

        assign src      = ex_rs[g*RW +: RW];
        assign mem_hit  = mem_regwrite && (mem_rd != '0) && (mem_rd == src);
        assign wb_hit   = wb_regwrite && (wb_rd != '0) && (wb_rd == src);
        assign hold_hit = (HOLD_EN != 0) && hold_v_q && (hold_rd_q == src);

        // Youngest producer wins: MEM, then WB, then the value that just left WB.
        always_comb begin
            sel  = 2'b00;
            data = ex_rdata[g*XLEN +: XLEN];
            if (mem_hit) begin
                sel  = 2'b10;
                data = mem_result;
            end else if (wb_hit) begin
                sel  = 2'b01;
                data = wb_data;
            end else if (hold_hit) begin
                sel  = 2'b11;
                data = hold_data_q;
            end
        end

        assign fwd_sel[g*2 +: 2]       = sel;
        assign fwd_out[g*XLEN +: XLEN] = data;
        assign fwd_any[g]              = |sel;
        assign rs_hit[g]               = (id_rs[g*RW +: RW] == ex_rd);
    end

    assign load_use = id_valid && ex_memread && ex_regwrite && (ex_rd != '0) && (|rs_hit);

    always_comb begin
        hold_v_d    = (HOLD_EN != 0) && wb_regwrite && (wb_rd != '0);
        hold_rd_d   = hold_rd_q;
        hold_data_d = hold_data_q;
        if (wb_regwrite && (wb_rd != '0)) begin
            hold_rd_d   = wb_rd;
            hold_data_d = wb_data;
        end
    end

    // The detection cycle itself is the first stall cycle; STALL covers the rest.
    always_comb begin
        state_d   = state_q;
        scnt_d    = scnt_q;
        stall_int = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall_int = load_use;
                if (load_use && (LOAD_STALL > 1)) begin
                    state_d = S_STALL;
                    scnt_d  = SCNT_INIT;
                end
            end
            S_STALL: begin
                stall_int = 1'b1;
                if (scnt_q == 2'd0) begin
                    state_d = S_IDLE;
                end else begin
                    scnt_d = scnt_q - 2'd1;
                end
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            fwd_cnt_d   = '0;
        end else begin
            if (stall_int && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if ((|fwd_any) && (fwd_cnt_q != CNT_MAX)) fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_v_q    <= 1'b0;
            hold_rd_q   <= '0;
            hold_data_q <= '0;
            state_q     <= S_IDLE;
            scnt_q      <= 2'd0;
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            hold_v_q    <= hold_v_d;
            hold_rd_q   <= hold_rd_d;
            hold_data_q <= hold_data_d;
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall     = rst_n && stall_int;
    assign bubble    = rst_n && stall_int;
    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the single-operand EX forwarding mux.
- Resolves all NSRC EX-stage operands from MEM, WB or a one-deep WB hold buffer.
- Detects load-use hazards and stalls for a configurable number of cycles, counting stall and forward events for performance debug.
- Sits between the ID/EX pipeline register and the ALU input muxes. Its stall and bubble outputs drive the PC/IF-ID enables and the ID/EX flush.

Parameters:
- XLEN, 32, datapath width.
- RW, 5, register-address width.
- NSRC, 2, number of source operands per instruction (1..4).
- LOAD_STALL, 1, load-use stall cycles (1..3).
- HOLD_EN, 1, enables the WB hold buffer and select code 2'b11.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a valid instruction.
- id_rs  in  NSRC*RW  ID-stage source register addresses, operand i at [i*RW +: RW].
- ex_rs  in  NSRC*RW  EX-stage source register addresses.
- ex_rdata  in  NSRC*XLEN  register-file operand values latched in ID/EX.
- ex_rd  in  RW  EX destination register.
- ex_regwrite  in  1  EX instruction writes a register.
- ex_memread  in  1  EX instruction is a load.
- mem_rd  in  RW  MEM destination register.
- mem_regwrite  in  1  MEM instruction writes a register.
- mem_result  in  XLEN  MEM-stage ALU result.
- wb_rd  in  RW  WB destination register.
- wb_regwrite  in  1  WB write enable.
- wb_data  in  XLEN  WB write data.
- cnt_clr  in  1  synchronous clear of both counters.
- fwd_out  out  NSRC*XLEN  resolved EX operands.
- fwd_sel  out  NSRC*2  per-operand source code.
- stall  out  1  freeze PC and IF/ID.
- bubble  out  1  flush ID/EX to a NOP.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- fwd_cnt  out  CNT_W  saturating count of cycles with any forwarded operand.

Behaviour:
- Clock and reset: single clock domain clk. rst_n is asynchronous, active-low.
- Reset values:
  - FSM in IDLE.
  - Counters 0.
  - Hold buffer invalid (hold_v=0, hold_rd=0, hold_data=0).
  - stall and bubble forced to 0 while rst_n is low.
- Forward select, combinational and zero-latency, per operand i:
  - 2'b10 (mem_result) if mem_regwrite and mem_rd!=0 and mem_rd==ex_rs[i].
  - else 2'b01 (wb_data) if wb_regwrite and wb_rd!=0 and wb_rd==ex_rs[i].
  - else 2'b11 (hold_data) if HOLD_EN and hold_v and hold_rd==ex_rs[i].
  - else 2'b00 (ex_rdata[i]).
  - Priority is MEM > WB > hold > register file. Register 0 is never forwarded.
- Hold buffer:
  - At each rising edge with wb_regwrite and wb_rd!=0: capture hold_rd<=wb_rd, hold_data<=wb_data, hold_v<=1.
  - Edge with no WB write: hold_v<=0. The buffer covers exactly one cycle after WB.
  - HOLD_EN=0: hold_v stays 0.
- Load-use detect (use): id_valid and ex_memread and ex_regwrite and ex_rd!=0 and ex_rd equals any id_rs[i].
- FSM states IDLE and STALL, with down-counter scnt (2 bits):
  - IDLE: stall=bubble=use, combinational in the detection cycle. If use and LOAD_STALL>1, go to STALL with scnt<=LOAD_STALL-2.
  - STALL: stall=bubble=1 and detection is ignored. When scnt==0 go to IDLE, else scnt<=scnt-1.
  - Total stall cycles per hazard = LOAD_STALL exactly.
  - Reset mid-stall: return to IDLE immediately and deassert stall.
- Counters, updated at the rising edge:
  - stall_cnt increments when stall=1.
  - fwd_cnt increments when any fwd_sel!=00.
  - Both saturate at 2^CNT_W-1 (no wrap).
  - cnt_clr takes priority over increment and loads 0 the same edge.
- Width rules:
  - All comparisons are exact RW-bit comparisons.
  - fwd_out slices are XLEN bits with no sign extension.
  - Out-of-range parameters are a compile-time error (generate assertion).

Test Plan:
- MEM priority: ex_rs0=3, mem_rd=3, mem_regwrite=1, mem_result=0xAAAA0001, wb_rd=3, wb_regwrite=1, wb_data=0x5 -> fwd_sel[1:0]=10, fwd_out0=0xAAAA0001, fwd_cnt +1.
- Register zero: ex_rs0=0, mem_rd=0, mem_regwrite=1, ex_rdata0=0 -> sel=00, fwd_out0=0, fwd_cnt unchanged.
- Hold buffer: cycle N wb_rd=7, wb_data=0x1234, write enabled. Cycle N+1 no WB write, ex_rs1=7 -> fwd_sel[3:2]=11, fwd_out1=0x1234. Cycle N+2: sel=00.
- Load-use with LOAD_STALL=2: ex_memread=1, ex_regwrite=1, ex_rd=9, id_rs1=9, id_valid=1 -> stall=bubble=1 for exactly 2 cycles, stall_cnt=2, then 0. Same stimulus with id_valid=0 -> no stall.
- Reset mid-stall: LOAD_STALL=3, assert rst_n=0 during the second stall cycle -> stall=0 asynchronously. After release: FSM in IDLE, counters 0.
- Saturation and clear: CNT_W=4, 20 consecutive stall cycles -> stall_cnt=15. cnt_clr=1 while a stall is active -> stall_cnt=0 on that edge.
